// File: rtl/ebpf_divmod_seq.sv
// ---------------------------------------------------------------------------
// ebpf_divmod_seq
//
// Multi-cycle unsigned divide / modulo engine for the eBPF ALU (BPF_DIV and
// BPF_MOD, ALU64 and ALU32 classes). A radix-2 restoring divider resolves one
// quotient bit per cycle. This keeps the wide combinational quotient path off
// the critical path.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high and kill is low. Once valid is raised, the
// payload is not read anywhere except at that transfer edge. kill takes
// priority over every transfer that would occur on the same edge.
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   in_valid / in_ready   operation offered / engine idle and able to accept
//   op_mod                0 = quotient, 1 = remainder
//   is_alu32              1 = 32-bit operation (operands truncated, result
//                         zero-extended)
//   dividend, divisor     operands, sampled only at the accept edge
//   tag_in                destination register tag carried with the op
//   kill                  synchronous abort of anything in flight
//   out_valid / out_ready result available / writeback accepts
//   result, tag_out       result payload; held while out_valid && !out_ready,
//                         retained after drain
//   busy                  high in CALC or DONE
//   dbg_state             current FSM state (0 IDLE, 1 CALC, 2 DONE)
// ---------------------------------------------------------------------------
module ebpf_divmod_seq #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              op_mod,
    input  logic              is_alu32,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic              kill,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [TAG_W-1:0]  tag_out,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int HALF_W = 32;
    localparam int CNT_W  = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DATA_W-1:0] r_rem;      // partial remainder (always < divisor)
    logic [DATA_W-1:0] r_quo;      // quotient bits shifted in LSB-first
    logic [DATA_W-1:0] r_dvd;      // dividend, MSB consumed each cycle
    logic [DATA_W-1:0] r_dvs;
    logic [CNT_W-1:0]  r_cnt;      // iterations still to run
    logic              r_op_mod;
    logic              r_alu32;
    logic [TAG_W-1:0]  r_tag;      // tag of the op in flight
    logic [DATA_W-1:0] r_result;
    logic [TAG_W-1:0]  r_tag_out;

    logic              w_accept;
    logic              w_drain;
    logic              w_last;
    logic              w_div_zero;
    logic [DATA_W-1:0] w_dvd_in;   // dividend after ALU32 truncation
    logic [DATA_W-1:0] w_dvs_in;   // divisor after ALU32 truncation
    logic [DATA_W-1:0] w_dvd_load; // dividend aligned so its top bit is MSB
    logic [DATA_W:0]   w_shift;    // DATA_W+1 bit shifted partial remainder
    logic [DATA_W:0]   w_diff;
    logic              w_ge;
    logic [DATA_W-1:0] w_rem_next;
    logic [DATA_W-1:0] w_quo_next;
    logic [DATA_W-1:0] w_sel;
    logic [DATA_W-1:0] w_result_fmt;

    // ---------------------------------------------------------------
    // Handshake qualifiers
    // ---------------------------------------------------------------
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;
    assign result    = r_result;
    assign tag_out   = r_tag_out;

    assign w_accept = in_valid && in_ready && !kill;
    assign w_drain  = out_valid && out_ready && !kill;
    assign w_last   = (r_state == S_CALC) && (r_cnt == CNT_W'(1));

    // ---------------------------------------------------------------
    // Operand conditioning at accept
    // ---------------------------------------------------------------
    assign w_dvd_in   = is_alu32 ? {{(DATA_W-HALF_W){1'b0}}, dividend[HALF_W-1:0]} : dividend;
    assign w_dvs_in   = is_alu32 ? {{(DATA_W-HALF_W){1'b0}}, divisor[HALF_W-1:0]}  : divisor;
    assign w_div_zero = (w_dvs_in == '0);
    // An ALU32 dividend is parked in the upper half so that the same
    // MSB-first shift feeds its 32 bits in 32 iterations.
    assign w_dvd_load = is_alu32 ? {dividend[HALF_W-1:0], {(DATA_W-HALF_W){1'b0}}} : dividend;

    // ---------------------------------------------------------------
    // One restoring iteration
    // ---------------------------------------------------------------
    assign w_shift    = {r_rem, r_dvd[DATA_W-1]};
    assign w_diff     = w_shift - {1'b0, r_dvs};
    assign w_ge       = ~w_diff[DATA_W];
    assign w_rem_next = w_ge ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
    assign w_quo_next = {r_quo[DATA_W-2:0], w_ge};

    assign w_sel        = r_op_mod ? w_rem_next : w_quo_next;
    assign w_result_fmt = r_alu32 ? {{(DATA_W-HALF_W){1'b0}}, w_sel[HALF_W-1:0]} : w_sel;

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_div_zero ? S_DONE : S_CALC;
            S_CALC: if (w_last)   w_next = S_DONE;
            S_DONE: if (w_drain)  w_next = S_IDLE;
            default:              w_next = S_IDLE;
        endcase
        if (kill) begin
            w_next = S_IDLE;
        end
    end

    // ---------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_cnt     <= '0;
            r_op_mod  <= 1'b0;
            r_alu32   <= 1'b0;
            r_tag     <= '0;
            r_result  <= '0;
            r_tag_out <= '0;
        end else if (w_accept) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvd    <= w_dvd_load;
            r_dvs    <= w_dvs_in;
            r_cnt    <= is_alu32 ? CNT_W'(HALF_W) : CNT_W'(DATA_W);
            r_op_mod <= op_mod;
            r_alu32  <= is_alu32;
            r_tag    <= tag_in;
            // Divide by zero: DIV yields 0, MOD yields the (truncated) dividend.
            if (w_div_zero) begin
                r_result  <= op_mod ? w_dvd_in : '0;
                r_tag_out <= tag_in;
            end
        end else if ((r_state == S_CALC) && !kill) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_dvd <= r_dvd << 1;
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_last) begin
                r_result  <= w_result_fmt;
                r_tag_out <= r_tag;
            end
        end
    end

endmodule

// File: tb/tb_ebpf_divmod_seq.sv
module tb_ebpf_divmod_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        op_mod;
    logic        is_alu32;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic [3:0]  tag_in;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic [3:0]  tag_out;
    logic        busy;
    logic [1:0]  dbg_state;

    int checks;
    int failures;

    ebpf_divmod_seq #(.DATA_W(64), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_mod    (op_mod),
        .is_alu32  (is_alu32),
        .dividend  (dividend),
        .divisor   (divisor),
        .tag_in    (tag_in),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .tag_out   (tag_out),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver ----------------
    // Offers one op, scrambles the inputs after the accept edge, waits for
    // out_valid (latency counted in cycles after the accept cycle, 0 on
    // timeout), captures the payload and drains it.
    task automatic do_op(input logic m, input logic a32, input logic [63:0] dv,
                         input logic [63:0] ds, input logic [3:0] t,
                         output logic [63:0] res, output logic [3:0] tg,
                         output int lat, output logic rdy_leak);
        @(negedge clk);
        in_valid = 1'b1; op_mod = m; is_alu32 = a32;
        dividend = dv; divisor = ds; tag_in = t;
        @(negedge clk);
        in_valid = 1'b0;
        op_mod   = ~m;
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
        tag_in   = 4'($urandom_range(0, 15));
        lat      = 0;
        rdy_leak = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
            if (in_ready !== 1'b0) rdy_leak = 1'b1;
            @(negedge clk);
        end
        res = result;
        tg  = tag_out;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (result !== 64'd0) begin failures++; $display("FAIL reset_result got %h exp 0", result); end
        checks++; if (tag_out !== 4'd0) begin failures++; $display("FAIL reset_tag got %h exp 0", tag_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_alu64_div;
        logic [63:0] r; logic [3:0] t; int lat; logic leak;
        do_op(1'b0, 1'b0, 64'd100, 64'd7, 4'd5, r, t, lat, leak);
        checks++; if (r !== 64'd14) begin failures++; $display("FAIL div64_result got %h exp %h", r, 64'd14); end
        checks++; if (t !== 4'd5) begin failures++; $display("FAIL div64_tag got %h exp 5", t); end
        checks++; if (lat !== 65) begin failures++; $display("FAIL div64_latency got %0d exp 65", lat); end
        checks++; if (leak !== 1'b0) begin failures++; $display("FAIL div64_in_ready_low got leak=%b exp 0", leak); end
        do_op(1'b0, 1'b0, 64'hDEAD_BEEF_CAFE_BABE, 64'h10, 4'd2, r, t, lat, leak);
        checks++; if (r !== 64'h0DEA_DBEE_FCAF_EBAB) begin failures++; $display("FAIL div64_shift got %h exp 0deadbeefcafebab", r); end
    endtask

    task automatic test_alu64_mod_extremes;
        logic [63:0] r; logic [3:0] t; int lat; logic leak;
        do_op(1'b1, 1'b0, 64'd100, 64'd7, 4'd6, r, t, lat, leak);
        checks++; if (r !== 64'd2) begin failures++; $display("FAIL mod64_result got %h exp 2", r); end
        checks++; if (lat !== 65) begin failures++; $display("FAIL mod64_latency got %0d exp 65", lat); end
        do_op(1'b1, 1'b0, 64'hDEAD_BEEF_CAFE_BABE, 64'h10, 4'd7, r, t, lat, leak);
        checks++; if (r !== 64'hE) begin failures++; $display("FAIL mod64_shift got %h exp e", r); end
        do_op(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd8, r, t, lat, leak);
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL max_div_1 got %h exp ffffffffffffffff", r); end
        do_op(1'b0, 1'b0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 4'd9, r, t, lat, leak);
        checks++; if (r !== 64'd0) begin failures++; $display("FAIL small_div_max got %h exp 0", r); end
    endtask

    task automatic test_alu32_trunc;
        logic [63:0] r; logic [3:0] t; int lat; logic leak;
        do_op(1'b0, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'h0000_0001_0000_0007, 4'd10, r, t, lat, leak);
        checks++; if (r !== 64'hE) begin failures++; $display("FAIL div32_result got %h exp e", r); end
        checks++; if (lat !== 33) begin failures++; $display("FAIL div32_latency got %0d exp 33", lat); end
        checks++; if (t !== 4'd10) begin failures++; $display("FAIL div32_tag got %h exp a", t); end
        do_op(1'b1, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'h0000_0001_0000_0007, 4'd11, r, t, lat, leak);
        checks++; if (r !== 64'h2) begin failures++; $display("FAIL mod32_result got %h exp 2", r); end
        do_op(1'b0, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'h0000_0000_0000_0001, 4'd1, r, t, lat, leak);
        checks++; if (r !== 64'h0000_0000_FFFF_FFFF) begin failures++; $display("FAIL div32_zext got %h exp ffffffff", r); end
    endtask

    task automatic test_div_zero;
        logic [63:0] r; logic [3:0] t; int lat; logic leak;
        do_op(1'b0, 1'b0, 64'h1234, 64'd0, 4'd12, r, t, lat, leak);
        checks++; if (r !== 64'd0) begin failures++; $display("FAIL dz_div_result got %h exp 0", r); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL dz_div_latency got %0d exp 1", lat); end
        checks++; if (t !== 4'd12) begin failures++; $display("FAIL dz_div_tag got %h exp c", t); end
        do_op(1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 4'd13, r, t, lat, leak);
        checks++; if (r !== 64'h1234_5678_9ABC_DEF0) begin failures++; $display("FAIL dz_mod64 got %h exp 123456789abcdef0", r); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL dz_mod64_latency got %0d exp 1", lat); end
        // Upper half of the divisor is ignored in ALU32, so this is also zero.
        do_op(1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_0000_0000, 4'd14, r, t, lat, leak);
        checks++; if (r !== 64'h0000_0000_9ABC_DEF0) begin failures++; $display("FAIL dz_mod32 got %h exp 9abcdef0", r); end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        in_valid = 1'b1; op_mod = 1'b0; is_alu32 = 1'b1;
        dividend = 64'd1000; divisor = 64'd10; tag_in = 4'd3;
        @(negedge clk);
        // Second op queued while the first is busy.
        op_mod = 1'b1; dividend = 64'd1000; divisor = 64'd7; tag_in = 4'd9;
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            if (out_valid === 1'b1) begin lat = k; break; end
            @(negedge clk);
        end
        checks++; if (lat !== 33) begin failures++; $display("FAIL b2b_a_latency got %0d exp 33", lat); end
        checks++; if (result !== 64'd100) begin failures++; $display("FAIL b2b_a_result got %h exp 64", result); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid cyc %0d got %b exp 1", i, out_valid); end
            checks++; if (result !== 64'd100 || tag_out !== 4'd3) begin failures++; $display("FAIL bp_hold cyc %0d got %h/%h exp 64/3", i, result, tag_out); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc %0d got %b exp 0", i, in_ready); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_drain got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
        @(negedge clk);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL b2b_b_accept got busy=%b ir=%b exp 1/0", busy, in_ready); end
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            if (out_valid === 1'b1) begin lat = k; break; end
            @(negedge clk);
        end
        checks++; if (lat !== 33) begin failures++; $display("FAIL b2b_b_latency got %0d exp 33", lat); end
        checks++; if (result !== 64'd6 || tag_out !== 4'd9) begin failures++; $display("FAIL b2b_b_result got %h/%h exp 6/9", result, tag_out); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_kill;
        logic seen;
        @(negedge clk);
        in_valid = 1'b1; op_mod = 1'b0; is_alu32 = 1'b0;
        dividend = 64'd500; divisor = 64'd3; tag_in = 4'd4;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL kill_calc got ir=%b busy=%b exp 1/0", in_ready, busy); end
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL kill_no_output got seen=%b exp 0", seen); end
        // kill on the same edge as an offer
        in_valid = 1'b1; kill = 1'b1;
        dividend = 64'd9; divisor = 64'd0; tag_in = 4'd15;
        @(negedge clk);
        in_valid = 1'b0; kill = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL kill_vs_accept got busy=%b ir=%b exp 0/1", busy, in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL kill_vs_accept_out got seen=%b exp 0", seen); end
    endtask

    task automatic test_reset_mid_calc;
        logic [63:0] r; logic [3:0] t; int lat; logic leak;
        @(negedge clk);
        in_valid = 1'b1; op_mod = 1'b0; is_alu32 = 1'b0;
        dividend = 64'd777; divisor = 64'd5; tag_in = 4'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_ctrl got ov=%b busy=%b exp 0/0", out_valid, busy); end
        checks++; if (result !== 64'd0 || tag_out !== 4'd0) begin failures++; $display("FAIL rst_mid_data got %h/%h exp 0/0", result, tag_out); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready got %b exp 1", in_ready); end
        do_op(1'b0, 1'b0, 64'h10, 64'h4, 4'd2, r, t, lat, leak);
        checks++; if (r !== 64'd4 || t !== 4'd2) begin failures++; $display("FAIL post_reset_op got %h/%h exp 4/2", r, t); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; in_valid = 1'b0; op_mod = 1'b0; is_alu32 = 1'b0;
        dividend = '0; divisor = '0; tag_in = '0; kill = 1'b0; out_ready = 1'b0;
        test_reset();
        test_alu64_div();
        test_alu64_mod_extremes();
        test_alu32_trunc();
        test_div_zero();
        test_back_to_back();
        test_kill();
        test_reset_mid_calc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
